exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt controller directly upstream of the CP0 register file.
- Collects trap requests from the decode/execute stage (syscall, break, teq, eret) and one external interrupt line.
- Gates each source with the CP0 status word, prioritises the sources and drives CP0's exception/eret/cause/pc inputs as one-cycle registered pulses.
- Issues a PC redirect (exception vector or EPC) and a pipeline flush window to the fetch stage.

Parameters:
- EXC_VECTOR, 32'h0040_0004, redirect target on any taken exception.
- FLUSH_CYCLES, 2, flush cycles after a taken exception/eret; valid range 1..7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  decode/execute stage holds a valid instruction this cycle
- instr_pc  in  32  PC of that instruction
- req_syscall  in  1  instruction is SYSCALL
- req_break  in  1  instruction is BREAK
- req_teq  in  1  instruction is TEQ and its operands are equal
- req_eret  in  1  instruction is ERET
- irq  in  1  external interrupt, asynchronous, active-high level
- status_in  in  32  current CP0 status word
- epc_in  in  32  current CP0 EPC
- exception  out  1  one-cycle pulse to CP0 exception input
- eret  out  1  one-cycle pulse to CP0 eret input
- cause  out  32  cause word to CP0, valid while exception=1
- exc_pc  out  32  PC to CP0 for EPC capture, valid while exception=1
- redirect_valid  out  1  fetch must load redirect_pc this cycle
- redirect_pc  out  32  new fetch PC
- flush  out  1  squash younger pipeline stages
- busy  out  1  FSM not in IDLE; new requests ignored

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, synchroniser flops=0, irq_pending=0, flush counter=0. All outputs 0, including cause, exc_pc and redirect_pc.
- irq path:
  - Two-flop synchroniser feeds a rising-edge detector.
  - A detected edge sets irq_pending.
  - irq_pending clears only in the cycle an interrupt is taken.
  - Edges arriving while pending is already set are lost.
- Enable bits: IE=status_in[0], IM=status_in[1], syscall=status_in[8], break=status_in[9], teq=status_in[10].
  - A source is eligible only if IE=1 and its own bit=1.
  - A masked synchronous request is dropped with no response.
  - A masked interrupt stays pending.
- Sampling: only in IDLE with instr_valid=1. Priority, highest first: eret (always eligible), teq, syscall, break, interrupt.
- ExcCodes: syscall 5'd8, break 5'd9, teq 5'd13, interrupt 5'd0.
- FSM states: IDLE, TRAP, RET, FLUSH.
- IDLE -> TRAP on an eligible exception, cycle N. In cycle N+1 (state TRAP):
  - exception=1, cause={25'b0, code, 2'b0}, exc_pc=instr_pc sampled at N.
  - redirect_valid=1, redirect_pc=EXC_VECTOR, flush=1.
- IDLE -> RET on eret, cycle N. In cycle N+1 (state RET):
  - eret=1, redirect_valid=1, redirect_pc=epc_in as presented in N+1, flush=1.
- TRAP/RET -> FLUSH:
  - flush stays 1 for FLUSH_CYCLES-1 further cycles, then the FSM returns to IDLE.
  - With FLUSH_CYCLES=1, TRAP/RET -> IDLE directly.
- Pulse widths: exception, eret and redirect_valid are exactly one cycle wide. cause and exc_pc hold their last value afterwards.
- busy=1 in TRAP, RET and FLUSH. Requests presented while busy are ignored; they belong to squashed instructions.
- Simultaneous events:
  - eret together with a pending irq: eret wins, irq remains pending.
  - teq and syscall together: teq wins.
  - An irq edge that coincides with being taken: pending clears. The new edge is lost only if it was detected in that same cycle.
- Reset asserted mid-sequence returns the FSM to IDLE immediately and drops all pulses.
- instr_valid=0 in IDLE: no state change; irq_pending is retained.

Decomposition:
- Shared package cp0_pkg holds:
  - ExcCode constants (EXC_INT=0, EXC_SYS=8, EXC_BRK=9, EXC_TEQ=13).
  - Status bit indices (ST_IE=0, ST_IM=1, ST_SYS=8, ST_BRK=9, ST_TEQ=10).
  - FSM state enum.
- One natural sub-module: irq_sync, the 2-flop synchroniser, edge detector and pending latch with clear input.

Test Plan:
- Syscall: status_in=32'h0000_0101, instr_pc=32'h0040_0020, req_syscall=1 at cycle N -> cycle N+1 exception=1, cause=32'h20, exc_pc=32'h0040_0020, redirect_pc=32'h0040_0004; flush high cycles N+1..N+2; busy low at N+3.
- Masked: status_in=32'h0000_0001, req_break=1 -> no exception, busy stays 0. Then status_in=32'h0000_0201, req_break=1 -> cause=32'h24.
- Eret: req_eret=1, epc_in=32'h0040_0100 -> next cycle eret=1, redirect_pc=32'h0040_0100, exception=0.
- Interrupt: irq rises while status_in=32'h0000_0000 -> no exception for 10 cycles, pending held. Then status_in=32'h0000_0003 with instr_valid=1 -> exception=1, cause=32'h0.
- Priority: req_teq=1 and req_syscall=1, status_in=32'h0000_0501 -> cause=32'h34. A request during the flush window -> ignored.
- Reset: rst low during the FLUSH state -> all outputs 0 asynchronously. After release, IDLE with irq_pending=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: ExcCodes, status-word bit positions and the
// exception controller state encoding.
package cp0_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BRK = 5'd9;
    localparam logic [4:0] EXC_TEQ = 5'd13;

    localparam int ST_IE  = 0;
    localparam int ST_IM  = 1;
    localparam int ST_SYS = 8;
    localparam int ST_BRK = 9;
    localparam int ST_TEQ = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_RET,
        S_FLUSH
    } exc_state_e;

    // Cause word layout: ExcCode sits in bits [6:2].
    function automatic logic [31:0] make_cause(input logic [4:0] code);
        return {25'b0, code, 2'b0};
    endfunction

endpackage

// File: rtl/irq_sync.sv
// External interrupt front end: two-flop synchroniser, rising-edge detector
// and a pending latch that only the controller's take signal clears.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clear,
    output logic pending
);

    logic sync1;
    logic sync2;
    logic sync_prev;
    logic edge_det;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= irq;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign edge_det = sync2 & ~sync_prev;

    // Clear wins over a same-cycle edge, so that edge is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (edge_det) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller ahead of CP0: gates and prioritises trap
// sources, pulses CP0 exception/eret and redirects/flushes the front end.
module exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_pc,
    input  logic        req_syscall,
    input  logic        req_break,
    input  logic        req_teq,
    input  logic        req_eret,
    input  logic        irq,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    output logic        exception,
    output logic        eret,
    output logic [31:0] cause,
    output logic [31:0] exc_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy
);

    // FLUSH holds for FLUSH_CYCLES-1 cycles; counter loads the last index.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 2);

    exc_state_e  state;
    logic [2:0]  flush_cnt;
    logic        irq_pending;
    logic        ie;
    logic        teq_ok;
    logic        sys_ok;
    logic        brk_ok;
    logic        int_ok;
    logic        sample;
    logic        take_eret;
    logic        take_exc;
    logic        take_int;
    logic [4:0]  exc_code;
    logic        unused_status;

    assign unused_status = ^{status_in[31:11], status_in[7:2]};

    irq_sync u_irq_sync (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .clear   (take_int),
        .pending (irq_pending)
    );

    assign ie     = status_in[ST_IE];
    assign teq_ok = req_teq     & ie & status_in[ST_TEQ];
    assign sys_ok = req_syscall & ie & status_in[ST_SYS];
    assign brk_ok = req_break   & ie & status_in[ST_BRK];
    assign int_ok = irq_pending & ie & status_in[ST_IM];

    assign sample    = (state == S_IDLE) & instr_valid;
    assign take_eret = sample & req_eret;
    assign take_exc  = sample & ~req_eret & (teq_ok | sys_ok | brk_ok | int_ok);
    assign take_int  = take_exc & ~teq_ok & ~sys_ok & ~brk_ok;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        exc_code = EXC_INT;
        if (teq_ok)      exc_code = EXC_TEQ;
        else if (sys_ok) exc_code = EXC_SYS;
        else if (brk_ok) exc_code = EXC_BRK;
    end

    // EPC is forwarded live in RET so a same-cycle CP0 update is honoured.
    always_comb begin
        redirect_pc = '0;
        case (state)
            S_TRAP:  redirect_pc = EXC_VECTOR;
            S_RET:   redirect_pc = epc_in;
            default: redirect_pc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            flush_cnt      <= '0;
            exception      <= 1'b0;
            eret           <= 1'b0;
            cause          <= '0;
            exc_pc         <= '0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            exception      <= 1'b0;
            eret           <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take_eret) begin
                        state          <= S_RET;
                        eret           <= 1'b1;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        busy           <= 1'b1;
                    end else if (take_exc) begin
                        state          <= S_TRAP;
                        exception      <= 1'b1;
                        cause          <= make_cause(exc_code);
                        exc_pc         <= instr_pc;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                S_TRAP, S_RET: begin
                    if (FLUSH_CYCLES == 1) begin
                        state <= S_IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        state     <= S_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= S_IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized
// transactions scored against a priority/eligibility reference model.
module tb_exc_ctrl;

    localparam logic [31:0] EXC_VECTOR   = 32'h0040_0004;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_pc = '0;
    logic        req_syscall = 1'b0;
    logic        req_break = 1'b0;
    logic        req_teq = 1'b0;
    logic        req_eret = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] status_in = '0;
    logic [31:0] epc_in = '0;
    logic        exception;
    logic        eret;
    logic [31:0] cause;
    logic [31:0] exc_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    logic model_pending = 1'b0;

    exc_ctrl #(
        .EXC_VECTOR   (EXC_VECTOR),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .req_syscall    (req_syscall),
        .req_break      (req_break),
        .req_teq        (req_teq),
        .req_eret       (req_eret),
        .irq            (irq),
        .status_in      (status_in),
        .epc_in         (epc_in),
        .exception      (exception),
        .eret           (eret),
        .cause          (cause),
        .exc_pc         (exc_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ctrl_bits();
        return {exception, eret, redirect_valid, flush, busy};
    endfunction

    // Reference: kind 0 = no response, 1 = exception, 2 = eret.
    function automatic void predict(input logic v, input logic e, input logic t,
                                    input logic s, input logic b,
                                    input logic [31:0] st, input logic pend,
                                    output int kind, output logic [4:0] code);
        kind = 0;
        code = 5'd0;
        if (!v) return;
        if (e) begin
            kind = 2;
        end else if (st[0] && t && st[10]) begin
            kind = 1; code = 5'd13;
        end else if (st[0] && s && st[8]) begin
            kind = 1; code = 5'd8;
        end else if (st[0] && b && st[9]) begin
            kind = 1; code = 5'd9;
        end else if (st[0] && pend && st[1]) begin
            kind = 1; code = 5'd0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        req_syscall = 1'b0;
        req_break   = 1'b0;
        req_teq     = 1'b0;
        req_eret    = 1'b0;
    endtask

    // Produce a clean irq edge and wait until it is latched as pending.
    task automatic raise_irq();
        irq = 1'b1;
        repeat (2) tick();
        irq = 1'b0;
        repeat (4) tick();
        model_pending = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ctrl_bits(), cause, exc_pc, redirect_pc} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ctrl=%b cause=%h exc_pc=%h rpc=%h want all zero",
                     ctrl_bits(), cause, exc_pc, redirect_pc);
        end
        #3 rst = 1'b1;
        tick();
        checks++;
        if (ctrl_bits() !== 5'b00000) begin
            failures++;
            $display("FAIL reset_release_idle: got ctrl=%b want 00000", ctrl_bits());
        end
    endtask

    task automatic test_syscall();
        status_in   = 32'h0000_0101;
        instr_pc    = 32'h0040_0020;
        req_syscall = 1'b1;
        instr_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (ctrl_bits() !== 5'b10111) begin
            failures++;
            $display("FAIL syscall_ctrl: got %b want 10111", ctrl_bits());
        end
        checks++;
        if (cause !== 32'h20 || exc_pc !== 32'h0040_0020 || redirect_pc !== 32'h0040_0004) begin
            failures++;
            $display("FAIL syscall_data: got cause=%h exc_pc=%h rpc=%h want 20 00400020 00400004",
                     cause, exc_pc, redirect_pc);
        end
        for (int i = 1; i < FLUSH_CYCLES; i++) begin
            tick();
            checks++;
            if (ctrl_bits() !== 5'b00011 || cause !== 32'h20) begin
                failures++;
                $display("FAIL syscall_flush: got ctrl=%b cause=%h want 00011 20", ctrl_bits(), cause);
            end
        end
        tick();
        checks++;
        if (ctrl_bits() !== 5'b00000) begin
            failures++;
            $display("FAIL syscall_done: got ctrl=%b want 00000", ctrl_bits());
        end
    endtask

    task automatic test_masked();
        logic seen;
        seen        = 1'b0;
        status_in   = 32'h0000_0001;
        req_break   = 1'b1;
        instr_valid = 1'b1;
        tick();
        idle_inputs();
        seen = seen | (ctrl_bits() != 5'b00000);
        repeat (2) begin
            tick();
            seen = seen | (ctrl_bits() != 5'b00000);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL masked_break: got a response want none");
        end
        status_in   = 32'h0000_0201;
        instr_pc    = 32'h0040_0030;
        req_break   = 1'b1;
        instr_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (ctrl_bits() !== 5'b10111 || cause !== 32'h24) begin
            failures++;
            $display("FAIL enabled_break: got ctrl=%b cause=%h want 10111 24", ctrl_bits(), cause);
        end
        repeat (FLUSH_CYCLES) tick();
    endtask

    task automatic test_eret();
        status_in   = 32'h0000_0000;
        epc_in      = 32'h0040_0100;
        req_eret    = 1'b1;
        instr_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (ctrl_bits() !== 5'b01111 || redirect_pc !== 32'h0040_0100) begin
            failures++;
            $display("FAIL eret_pulse: got ctrl=%b rpc=%h want 01111 00400100", ctrl_bits(), redirect_pc);
        end
        epc_in = 32'h0040_0200;
        #1;
        checks++;
        if (redirect_pc !== 32'h0040_0200) begin
            failures++;
            $display("FAIL eret_live_epc: got rpc=%h want 00400200", redirect_pc);
        end
        repeat (FLUSH_CYCLES) tick();
        checks++;
        if (ctrl_bits() !== 5'b00000) begin
            failures++;
            $display("FAIL eret_done: got ctrl=%b want 00000", ctrl_bits());
        end
    endtask

    task automatic test_interrupt();
        logic seen;
        seen      = 1'b0;
        status_in = 32'h0000_0000;
        raise_irq();
        instr_valid = 1'b1;
        repeat (10) begin
            tick();
            seen = seen | exception;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL irq_masked: got exception want none");
        end
        status_in = 32'h0000_0003;
        instr_pc  = 32'h0040_0040;
        tick();
        instr_valid = 1'b0;
        model_pending = 1'b0;
        checks++;
        if (ctrl_bits() !== 5'b10111 || cause !== 32'h0 || exc_pc !== 32'h0040_0040) begin
            failures++;
            $display("FAIL irq_taken: got ctrl=%b cause=%h exc_pc=%h want 10111 0 00400040",
                     ctrl_bits(), cause, exc_pc);
        end
        repeat (FLUSH_CYCLES) tick();
        seen = 1'b0;
        instr_valid = 1'b1;
        repeat (3) begin
            tick();
            seen = seen | exception;
        end
        instr_valid = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL irq_cleared: got a second interrupt want none");
        end
    endtask

    task automatic test_priority();
        logic seen;
        status_in   = 32'h0000_0501;
        req_teq     = 1'b1;
        req_syscall = 1'b1;
        instr_valid = 1'b1;
        tick();
        req_teq = 1'b0;
        checks++;
        if (ctrl_bits() !== 5'b10111 || cause !== 32'h34) begin
            failures++;
            $display("FAIL teq_over_syscall: got ctrl=%b cause=%h want 10111 34", ctrl_bits(), cause);
        end
        seen = 1'b0;
        for (int i = 1; i < FLUSH_CYCLES; i++) begin
            tick();
            seen = seen | exception | eret;
        end
        idle_inputs();
        repeat (2) begin
            tick();
            seen = seen | exception | eret;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignored: got a pulse for a squashed request want none");
        end
        status_in = 32'h0000_0003;
        raise_irq();
        epc_in      = 32'h0040_0300;
        req_eret    = 1'b1;
        instr_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (ctrl_bits() !== 5'b01111) begin
            failures++;
            $display("FAIL eret_over_irq: got ctrl=%b want 01111", ctrl_bits());
        end
        repeat (FLUSH_CYCLES) tick();
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        model_pending = 1'b0;
        checks++;
        if (ctrl_bits() !== 5'b10111 || cause !== 32'h0) begin
            failures++;
            $display("FAIL irq_after_eret: got ctrl=%b cause=%h want 10111 0", ctrl_bits(), cause);
        end
        repeat (FLUSH_CYCLES) tick();
    endtask

    task automatic test_random();
        int          kind;
        logic [4:0]  code;
        logic [4:0]  exp_ctrl;
        logic [31:0] exp_rpc;
        for (int n = 0; n < 60; n++) begin
            if (!model_pending && ($urandom_range(0, 3) == 0)) raise_irq();
            instr_valid = ($urandom_range(0, 4) != 0);
            req_eret    = ($urandom_range(0, 5) == 0);
            req_teq     = $urandom_range(0, 1);
            req_syscall = $urandom_range(0, 1);
            req_break   = $urandom_range(0, 1);
            status_in   = $urandom;
            instr_pc    = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            epc_in      = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            predict(instr_valid, req_eret, req_teq, req_syscall, req_break,
                    status_in, model_pending, kind, code);
            exp_ctrl = (kind == 1) ? 5'b10111 : (kind == 2) ? 5'b01111 : 5'b00000;
            exp_rpc  = (kind == 1) ? EXC_VECTOR : epc_in;
            tick();
            idle_inputs();
            checks++;
            if (ctrl_bits() !== exp_ctrl) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: got %b want %b", n, ctrl_bits(), exp_ctrl);
            end
            if (kind == 1) begin
                checks++;
                if (cause !== {25'b0, code, 2'b0} || exc_pc !== instr_pc) begin
                    failures++;
                    $display("FAIL rand_exc_data[%0d]: got cause=%h exc_pc=%h want %h %h",
                             n, cause, exc_pc, {25'b0, code, 2'b0}, instr_pc);
                end
                if (code == 5'd0) model_pending = 1'b0;
            end
            if (kind != 0) begin
                checks++;
                if (redirect_pc !== exp_rpc) begin
                    failures++;
                    $display("FAIL rand_redirect[%0d]: got %h want %h", n, redirect_pc, exp_rpc);
                end
                for (int i = 1; i < FLUSH_CYCLES; i++) begin
                    instr_valid = 1'b1;
                    req_eret    = $urandom_range(0, 1);
                    req_teq     = $urandom_range(0, 1);
                    req_syscall = $urandom_range(0, 1);
                    req_break   = $urandom_range(0, 1);
                    tick();
                    checks++;
                    if (ctrl_bits() !== 5'b00011) begin
                        failures++;
                        $display("FAIL rand_flush[%0d]: got %b want 00011", n, ctrl_bits());
                    end
                end
                idle_inputs();
                tick();
                checks++;
                if (ctrl_bits() !== 5'b00000) begin
                    failures++;
                    $display("FAIL rand_idle[%0d]: got %b want 00000", n, ctrl_bits());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        status_in = 32'h0000_0101;
        raise_irq();
        instr_pc    = 32'h0040_0080;
        req_syscall = 1'b1;
        instr_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({ctrl_bits(), cause, exc_pc, redirect_pc} !== '0) begin
            failures++;
            $display("FAIL reset_mid_flush: got ctrl=%b cause=%h exc_pc=%h rpc=%h want all zero",
                     ctrl_bits(), cause, exc_pc, redirect_pc);
        end
        #2 rst = 1'b1;
        model_pending = 1'b0;
        status_in   = 32'h0000_0003;
        instr_valid = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | (ctrl_bits() != 5'b00000);
        end
        instr_valid = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_clears_pending: got a response want none");
        end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_masked();
        test_eret();
        test_interrupt();
        test_priority();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
